// File: rtl/cpu_pkg.sv
// Shared definitions for the ALU microcode sequencer: opcodes, FSM states,
// bus-source indices and one-hot ALU control bit positions.
package cpu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SHR  = 4'd4;
    localparam logic [3:0] OP_SHRA = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_ROR  = 4'd7;
    localparam logic [3:0] OP_ROL  = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;
    localparam logic [3:0] OP_DIV  = 4'd10;
    localparam logic [3:0] OP_NEG  = 4'd11;
    localparam logic [3:0] OP_NOT  = 4'd12;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOADY = 3'd1,
        S_EXEC  = 3'd2,
        S_WBLO  = 3'd3,
        S_WBHI  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Bus sources above the sixteen general registers
    localparam int BUS_HI     = 16;
    localparam int BUS_LO     = 17;
    localparam int BUS_ZHI    = 18;
    localparam int BUS_ZLO    = 19;
    localparam int BUS_PC     = 20;
    localparam int BUS_MDR    = 21;
    localparam int BUS_INPORT = 22;
    localparam int BUS_CSIGN  = 23;

    localparam int ALU_W    = 13;
    localparam int ALU_NOT  = 0;
    localparam int ALU_OR   = 1;
    localparam int ALU_AND  = 2;
    localparam int ALU_SHR  = 3;
    localparam int ALU_SHRA = 4;
    localparam int ALU_SHL  = 5;
    localparam int ALU_ADD  = 6;
    localparam int ALU_NEG  = 7;
    localparam int ALU_SUB  = 8;
    localparam int ALU_ROR  = 9;
    localparam int ALU_ROL  = 10;
    localparam int ALU_DIV  = 11;
    localparam int ALU_MUL  = 12;

    function automatic logic is_unary(input logic [3:0] op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

    // MUL/DIV produce a 64-bit result that needs both Z halves
    function automatic logic is_long(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational opcode to one-hot ALU control decode; flags opcodes 13-15.
module alu_op_decoder
    import cpu_pkg::*;
(
    input  logic [3:0]       op,
    output logic [ALU_W-1:0] alu_onehot,
    output logic             illegal
);

    always_comb begin
        alu_onehot = '0;
        illegal    = 1'b0;
        case (op)
            OP_ADD:  alu_onehot[ALU_ADD]  = 1'b1;
            OP_SUB:  alu_onehot[ALU_SUB]  = 1'b1;
            OP_AND:  alu_onehot[ALU_AND]  = 1'b1;
            OP_OR:   alu_onehot[ALU_OR]   = 1'b1;
            OP_SHR:  alu_onehot[ALU_SHR]  = 1'b1;
            OP_SHRA: alu_onehot[ALU_SHRA] = 1'b1;
            OP_SHL:  alu_onehot[ALU_SHL]  = 1'b1;
            OP_ROR:  alu_onehot[ALU_ROR]  = 1'b1;
            OP_ROL:  alu_onehot[ALU_ROL]  = 1'b1;
            OP_MUL:  alu_onehot[ALU_MUL]  = 1'b1;
            OP_DIV:  alu_onehot[ALU_DIV]  = 1'b1;
            OP_NEG:  alu_onehot[ALU_NEG]  = 1'b1;
            OP_NOT:  alu_onehot[ALU_NOT]  = 1'b1;
            default: illegal              = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Microcode sequencer driving bus selects and register enables for one ALU
// instruction at a time. Handshake: start is sampled only in IDLE; busy is
// high until the cycle after the done pulse, and start seen while busy is dropped.
module alu_sequencer
    import cpu_pkg::*;
(
    input  logic             Clock,
    input  logic             Clear,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [3:0]       ra,
    input  logic [3:0]       rb,
    input  logic [3:0]       rc,
    output logic [31:0]      busSel,
    output logic [15:0]      regIn,
    output logic             Yin,
    output logic             ZLOin,
    output logic             ZHIin,
    output logic             HIin,
    output logic             LOin,
    output logic [ALU_W-1:0] aluOp,
    output logic             busy,
    output logic             done,
    output logic             err,
    output state_t           dbg_state
);

    state_t           state, state_nx;
    logic [3:0]       op_q, ra_q, rb_q, rc_q;
    logic [ALU_W-1:0] alu_q;
    logic             err_q;
    logic [ALU_W-1:0] dec_onehot;
    logic             dec_illegal;
    logic             accept;

    alu_op_decoder u_dec (
        .op         (op),
        .alu_onehot (dec_onehot),
        .illegal    (dec_illegal)
    );

    assign accept    = (state == S_IDLE) && start && !dec_illegal;
    assign dbg_state = state;
    assign err       = err_q;

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state <= S_IDLE;
            op_q  <= '0;
            ra_q  <= '0;
            rb_q  <= '0;
            rc_q  <= '0;
            alu_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            err_q <= (state == S_IDLE) && start && dec_illegal;
            if (accept) begin
                op_q  <= op;
                ra_q  <= ra;
                rb_q  <= rb;
                rc_q  <= rc;
                alu_q <= dec_onehot;
            end
        end
    end

    always_comb begin
        state_nx = state;
        busSel   = '0;
        regIn    = '0;
        Yin      = 1'b0;
        ZLOin    = 1'b0;
        ZHIin    = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        aluOp    = '0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (accept) state_nx = is_unary(op) ? S_EXEC : S_LOADY;
            end
            S_LOADY: begin
                busSel[{1'b0, rb_q}] = 1'b1;
                Yin                  = 1'b1;
                state_nx             = S_EXEC;
            end
            S_EXEC: begin
                // Unary ops take their only operand straight from rb
                if (is_unary(op_q)) busSel[{1'b0, rb_q}] = 1'b1;
                else                busSel[{1'b0, rc_q}] = 1'b1;
                aluOp    = alu_q;
                ZLOin    = 1'b1;
                ZHIin    = is_long(op_q);
                state_nx = S_WBLO;
            end
            S_WBLO: begin
                busSel[BUS_ZLO] = 1'b1;
                if (is_long(op_q)) begin
                    LOin     = 1'b1;
                    state_nx = S_WBHI;
                end else begin
                    regIn[ra_q] = 1'b1;
                    state_nx    = S_DONE;
                end
            end
            S_WBHI: begin
                busSel[BUS_ZHI] = 1'b1;
                HIin            = 1'b1;
                state_nx        = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                busy     = 1'b0;
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized scoreboard bench for alu_sequencer: a reference model expands each
// accepted instruction into its expected per-cycle control vectors.
module tb_alu_sequencer;
    import cpu_pkg::*;

    localparam int W = 67;

    logic        Clock, Clear, start;
    logic [3:0]  op, ra, rb, rc;
    logic [31:0] busSel;
    logic [15:0] regIn;
    logic        Yin, ZLOin, ZHIin, HIin, LOin;
    logic [12:0] aluOp;
    logic        busy, done, err;
    state_t      dbg_state;

    alu_sequencer dut (
        .Clock(Clock), .Clear(Clear), .start(start), .op(op),
        .ra(ra), .rb(rb), .rc(rc), .busSel(busSel), .regIn(regIn),
        .Yin(Yin), .ZLOin(ZLOin), .ZHIin(ZHIin), .HIin(HIin), .LOin(LOin),
        .aluOp(aluOp), .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
    );

    // Clock / reset block
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int total = 0;
    int bad = 0;
    logic [W-1:0] exp_q[$];
    int err_pending = 0;
    int model_left = 0;

    // aluOp bit position for each legal opcode, from the control-word table
    int alu_pos[13] = '{6, 8, 2, 1, 3, 4, 5, 9, 10, 12, 11, 7, 0};

    function automatic logic [W-1:0] mk(int bus, int rg, bit y, bit zl, bit zh,
                                        bit hi, bit lo, int alu, bit dn);
        logic [31:0] b = '0;
        logic [15:0] r = '0;
        logic [12:0] a = '0;
        if (bus >= 0) b[bus] = 1'b1;
        if (rg >= 0)  r[rg]  = 1'b1;
        if (alu >= 0) a[alu] = 1'b1;
        return {b, r, y, zl, zh, hi, lo, a, dn};
    endfunction

    // Expected cycle sequence of one legal instruction; returns its busy length
    function automatic int push_trace(int o, int d, int s1, int s2);
        bit unary = (o == 11) || (o == 12);
        bit longr = (o == 9) || (o == 10);
        int n = 0;
        if (!unary) begin exp_q.push_back(mk(s1, -1, 1, 0, 0, 0, 0, -1, 0)); n++; end
        exp_q.push_back(mk(unary ? s1 : s2, -1, 0, 1, longr, 0, 0, alu_pos[o], 0)); n++;
        if (longr) begin
            exp_q.push_back(mk(19, -1, 0, 0, 0, 0, 1, -1, 0)); n++;
            exp_q.push_back(mk(18, -1, 0, 0, 0, 1, 0, -1, 0)); n++;
        end else begin
            exp_q.push_back(mk(19, d, 0, 0, 0, 0, 0, -1, 0)); n++;
        end
        exp_q.push_back(mk(-1, -1, 0, 0, 0, 0, 0, -1, 1)); n++;
        return n;
    endfunction

    // Reference model: accepts start only when idle, ignores it while busy
    always @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            model_left = 0;
            exp_q.delete();
            err_pending = 0;
        end else if (model_left > 0) begin
            model_left--;
        end else if (start) begin
            if (op > 4'd12) err_pending++;
            else model_left = push_trace(int'(op), int'(ra), int'(rb), int'(rc));
        end
    end

    // Monitor: compares DUT outputs against the expected queue every cycle
    always @(negedge Clock) begin
        logic [W-1:0] act, e;
        if (Clear) begin
            act = {busSel, regIn, Yin, ZLOin, ZHIin, HIin, LOin, aluOp, done};
            total++;
            if (busy) begin
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL trace: unexpected busy cycle act=%h", act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        bad++;
                        $display("FAIL trace: t=%0t state=%0d act=%h exp=%h", $time, dbg_state, act, e);
                    end
                end
            end else if (act !== '0) begin
                bad++;
                $display("FAIL idle_outputs: act=%h exp=0", act);
            end
            if (err) begin
                total++;
                if (err_pending == 0) begin
                    bad++;
                    $display("FAIL err_pulse: err=1 exp=0 t=%0t", $time);
                end else err_pending--;
            end
        end
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (model_left != 0 && guard < 50) begin
            @(negedge Clock);
            guard++;
        end
        if (model_left != 0) check("wait_idle_timeout", 64'(model_left), 64'd0);
    endtask

    // Driver: issue one instruction, measure start-edge to done latency
    task automatic send_lat(string name, logic [3:0] o, logic [3:0] d,
                            logic [3:0] s1, logic [3:0] s2, int exp_lat);
        int k;
        start = 1'b1; op = o; ra = d; rb = s1; rc = s2;
        for (k = 1; k <= 20; k++) begin
            @(negedge Clock);
            if (k == 1) start = 1'b0;
            if (done) break;
        end
        check(name, 64'(k), 64'(exp_lat));
        wait_idle();
    endtask

    task automatic drive_rand();
        start = 1'($urandom_range(0, 1));
        op = 4'($urandom_range(0, 15));
        ra = 4'($urandom_range(0, 15));
        rb = 4'($urandom_range(0, 15));
        rc = 4'($urandom_range(0, 15));
    endtask

    initial begin
        int n;
        Clear = 1'b0; start = 1'b0; op = '0; ra = '0; rb = '0; rc = '0;
        #3;
        check("reset_outputs", {busSel, regIn, Yin, ZLOin, ZHIin, HIin, LOin, aluOp, busy, done, err}, 64'd0);
        check("reset_state", 64'(dbg_state), 64'(S_IDLE));
        repeat (2) @(negedge Clock);
        Clear = 1'b1;
        // First start right on release of reset
        send_lat("lat_add_first", OP_ADD, 4'd3, 4'd1, 4'd2, 4);
        send_lat("lat_mul", OP_MUL, 4'd0, 4'd5, 4'd6, 5);
        send_lat("lat_not", OP_NOT, 4'd7, 4'd4, 4'd9, 3);
        send_lat("lat_neg_alias", OP_NEG, 4'd2, 4'd2, 4'd0, 3);
        send_lat("lat_sub_alias", OP_SUB, 4'd15, 4'd15, 4'd15, 4);

        // Illegal opcode
        start = 1'b1; op = 4'd14; ra = 4'd1; rb = 4'd2; rc = 4'd3;
        @(negedge Clock);
        start = 1'b0;
        check("illegal_busy", 64'(busy), 64'd0);
        check("illegal_err", 64'(err), 64'd1);
        @(negedge Clock);
        check("illegal_err_once", 64'(err), 64'd0);

        // Reset in the middle of EXEC
        start = 1'b1; op = OP_ADD; ra = 4'd4; rb = 4'd5; rc = 4'd6;
        @(negedge Clock);
        start = 1'b0;
        @(negedge Clock);
        check("pre_reset_state", 64'(dbg_state), 64'(S_EXEC));
        #2 Clear = 1'b0;
        #1;
        check("async_clear_outputs", {busSel, regIn, Yin, ZLOin, ZHIin, HIin, LOin, aluOp, busy, done, err}, 64'd0);
        check("async_clear_state", 64'(dbg_state), 64'(S_IDLE));
        @(negedge Clock);
        Clear = 1'b1;
        send_lat("lat_add_after_clear", OP_ADD, 4'd8, 4'd9, 4'd10, 4);

        // DIV with start held and operands changing every cycle
        start = 1'b1; op = OP_DIV; ra = 4'd1; rb = 4'd11; rc = 4'd12;
        for (int k = 0; k < 7; k++) begin
            @(negedge Clock);
            start = 1'b1;
            op = 4'($urandom_range(0, 12));
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rc = 4'($urandom_range(0, 15));
        end
        start = 1'b0;
        @(negedge Clock);
        wait_idle();

        // Random instructions, sometimes hammering inputs while busy
        for (int i = 0; i < 60; i++) begin
            start = 1'b1;
            op = 4'($urandom_range(0, 15));
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rc = 4'($urandom_range(0, 15));
            @(negedge Clock);
            if ($urandom_range(0, 1) == 1) begin
                n = $urandom_range(1, 6);
                for (int k = 0; k < n; k++) begin
                    drive_rand();
                    @(negedge Clock);
                end
            end
            start = 1'b0;
            @(negedge Clock);
            wait_idle();
            n = $urandom_range(0, 2);
            repeat (n) @(negedge Clock);
        end

        repeat (4) @(negedge Clock);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check("err_drained", 64'(err_pending), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset:
REQ-002 Clock  input  1  single clock; all state changes on rising edge.
REQ-003 Clear  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request one ALU instruction; sampled only in IDLE.
REQ-005 op  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHR, 5 SHRA, 6 SHL, 7 ROR, 8 ROL, 9 MUL, 10 DIV, 11 NEG, 12 NOT, 13-15 illegal.
REQ-006 ra, rb, rc  input  4 each  destination, first-source and second-source register indices.
REQ-007 busSel  output  32  one-hot bus-source select: bits 0-15 R0-R15, 16 HI, 17 LO, 18 ZHI, 19 ZLO, 20 PC, 21 MDR, 22 INPORT, 23 CSIGN; all zero means no driver.
REQ-008 regIn  output  16  one-hot load enable for R0-R15.
REQ-009 Yin, ZLOin, ZHIin, HIin, LOin  output  1 each  register load enables.
REQ-010 aluOp  output  13  one-hot ALU control, bit order NOT, OR, AND, SHR, SHRA, SHL, ADD, NEG, SUB, ROR, ROL, DIV, MUL (bit 0 = NOT).
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse on completion.
REQ-013 err  output  1  one-cycle pulse on an illegal opcode.

Function
REQ-014 States SHALL be IDLE, LOADY, EXEC, WBLO, WBHI and DONE, with all outputs Moore-decoded from the registered state and latched operands.
REQ-015 In IDLE with start=1 and a legal op, the block SHALL latch op/ra/rb/rc and transition: binary ops to LOADY; NEG/NOT to EXEC.
REQ-016 In IDLE with start=1 and an illegal op, the block SHALL stay in IDLE and pulse err for the next cycle; no other output changes.
REQ-017 In LOADY the block SHALL assert busSel[rb] and Yin, then go to EXEC.
REQ-018 In EXEC the block SHALL assert busSel[rc] for binary ops or busSel[rb] for unary ops, assert the decoded aluOp bit and ZLOin; for MUL/DIV it SHALL also assert ZHIin; then go to WBLO.
REQ-019 In WBLO the block SHALL assert busSel[19] (ZLO); for MUL/DIV it SHALL also assert LOin and go to WBHI; otherwise it SHALL assert regIn[ra] and go to DONE.
REQ-020 In WBHI the block SHALL assert busSel[18] (ZHI) and HIin, then go to DONE.
REQ-021 In DONE the block SHALL assert done=1 with all other enables zero, then return to IDLE.
REQ-022 Latency from the start sample edge to the done-high cycle SHALL be 4 cycles for binary ops, 3 for NEG/NOT and 5 for MUL/DIV.
REQ-023 start while busy SHALL be ignored and SHALL NOT be queued.
REQ-024 At most one busSel bit, one regIn bit and one aluOp bit SHALL be high in any cycle.
REQ-025 ra equal to rb or rc SHALL be legal; the operands are consumed before write-back.
REQ-026 Latched operands SHALL hold constant from LOADY/EXEC through DONE, regardless of input changes.

Reset
REQ-027 With Clear=0, the block SHALL enter IDLE immediately and force every output (busSel, regIn, Yin, ZLOin, ZHIin, HIin, LOin, aluOp, busy, done, err) to zero, including mid-operation.
REQ-028 On reset, latched operands SHALL clear to zero, and the first start SHALL be accepted on the first rising edge after Clear deasserts.

Structure
REQ-029 A shared package cpu_pkg SHALL hold the opcode constants, the state enumeration, the busSel bit indices (ZLO=19, ZHI=18, MDR=21, ...) and the aluOp bit positions.
REQ-030 The opcode-to-one-hot mapping SHALL be a sub-module alu_op_decoder: combinational, 4-bit in, 13-bit out plus an illegal flag.

Verification
REQ-031 ADD, ra=3, rb=1, rc=2, start pulsed once -> LOADY busSel=0x2 Yin; EXEC busSel=0x4, aluOp ADD, ZLOin; WBLO busSel=0x80000, regIn=0x0008; done 4 cycles after the start edge.
REQ-032 MUL, ra=0, rb=5, rc=6 -> EXEC asserts ZLOin and ZHIin with aluOp MUL; WBLO LOin with busSel bit 19; WBHI HIin with busSel bit 18; no regIn; done after 5 cycles.
REQ-033 NOT, ra=7, rb=4 -> LOADY skipped; EXEC busSel=0x10, aluOp NOT; regIn=0x0080 in WBLO; done after 3 cycles.
REQ-034 op=14 with start -> err pulses once; busy stays 0; all enables stay 0.
REQ-035 Clear driven low during EXEC -> all outputs 0 asynchronously, before the next edge; after release, a new ADD completes normally.
REQ-036 start re-asserted every cycle of a DIV with different operands -> only the first instruction executes; it writes LO/HI, then returns to IDLE and accepts the next start.
